// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for a shared multicycle datapath. The datapath has one
//   memory port, one ALU and PC/IR registers. Each instruction runs through
//   FETCH, DECODE, then execute/memory/writeback states according to its
//   opcode class. Memory accesses use a req/ack handshake.
//
//   Optional feature: define MEM_TIMEOUT_EN to add a memory watchdog. It also
//   adds the MEM_TIMEOUT/CNTW parameters, the bus_err port and a FAULT state.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   opcode       instr[31:26] from IR, valid from DECODE onward
//   zero         ALU zero flag, used by the branch state
//   mem_ack      memory completes the current request this cycle
//   mem_req      memory request; mem_we selects write
//   iord         address mux (0=PC, 1=ALUOut)
//   ir_we/pc_we  IR / PC load enables; pc_src selects the PC source
//   alu_src_a/b  ALU operand selects; alu_op is the ALU operation class
//   reg_dst      register destination select (1=rd, 0=rt)
//   reg_write    register file write enable
//   mem_to_reg   writeback data select (1=MDR, 0=ALUOut)
//   illegal_op   sticky flag for an undecodable opcode
//   bus_err      sticky memory timeout flag (MEM_TIMEOUT_EN only)
//   state_o      current state encoding, for debug
module multicycle_control #(
  parameter int OPW = 6
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW = 5
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_we,
  output logic           pc_we,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           mem_to_reg,
  output logic           illegal_op,
`ifdef MEM_TIMEOUT_EN
  output logic           bus_err,
`endif
  output logic [3:0]     state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MADR    = 4'd2,
    MRD     = 4'd3,
    MWB     = 4'd4,
    MWR     = 4'd5,
    REX     = 4'd6,
    RWB     = 4'd7,
    IEX     = 4'd8,
    IWB     = 4'd9,
    BR      = 4'd10,
    JMP     = 4'd11,
    ILLEGAL = 4'd12
`ifdef MEM_TIMEOUT_EN
    ,
    FAULT   = 4'd13
`endif
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
  } op_class_e;

  state_e         state, state_next;
  logic [OPW-1:0] op_q;
  logic           run_q;

  function automatic op_class_e decode_class(input logic [OPW-1:0] op);
    op_class_e c;
    if (op == OPW'(0))                              c = C_R;
    else if (op >= OPW'(8)  && op <= OPW'(14))      c = C_IMM;
    else if (op >= OPW'(32) && op <= OPW'(37))      c = C_LOAD;
    else if (op >= OPW'(40) && op <= OPW'(46))      c = C_STORE;
    else if (op == OPW'(1) ||
             (op >= OPW'(4) && op <= OPW'(7)))      c = C_BRANCH;
    else if (op == OPW'(2))                         c = C_JUMP;
    else                                            c = C_ILLEGAL;
    return c;
  endfunction

  // run_q stays low from reset until the first clock edge after reset is
  // released. That keeps every control output at 0 during reset. It also
  // makes the first memory request start cleanly on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // State register. op_q captures the opcode while DECODE is active, so later
  // states are unaffected by IR changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      op_q       <= '0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) op_q <= opcode;
      if (state == ILLEGAL) illegal_op <= 1'b1;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNTW-1:0] cnt;
  logic            timeout;

  // The watchdog counts cycles in which the request is waiting for an ack.
  // It restarts on every fresh entry into a memory state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state_next != state &&
          (state_next == FETCH || state_next == MRD || state_next == MWR))
        cnt <= '0;
      else if (mem_req && !mem_ack)
        cnt <= cnt + 1'b1;
      if (state == FAULT) bus_err <= 1'b1;
    end
  end

  // This is the last allowed waiting cycle. An ack in this same cycle still wins.
  assign timeout = (cnt == CNTW'(MEM_TIMEOUT - 1));
`endif

  // Next-state and Moore outputs. Everything stays 0 and the state holds
  // until run_q is set.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    if (run_q) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_we     = mem_ack;
          pc_we     = mem_ack;
          if (mem_ack) state_next = DECODE;
`ifdef MEM_TIMEOUT_EN
          else if (timeout) state_next = FAULT;
`endif
        end
        DECODE: begin
          // Precompute the branch target into ALUOut.
          alu_src_b = 2'b11;
          case (decode_class(opcode))
            C_R:                state_next = REX;
            C_IMM:              state_next = IEX;
            C_LOAD, C_STORE:    state_next = MADR;
            C_BRANCH:           state_next = BR;
            C_JUMP:             state_next = JMP;
            default:            state_next = ILLEGAL;
          endcase
        end
        MADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          state_next = (decode_class(op_q) == C_LOAD) ? MRD : MWR;
        end
        MRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ack) state_next = MWB;
`ifdef MEM_TIMEOUT_EN
          else if (timeout) state_next = FAULT;
`endif
        end
        MWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_next = FETCH;
        end
        MWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ack) state_next = FETCH;
`ifdef MEM_TIMEOUT_EN
          else if (timeout) state_next = FAULT;
`endif
        end
        REX: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b10;
          state_next = RWB;
        end
        RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          state_next = FETCH;
        end
        IEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          alu_op     = 2'b11;
          state_next = IWB;
        end
        IWB: begin
          reg_write  = 1'b1;
          state_next = FETCH;
        end
        BR: begin
          // Odd opcodes branch on not-equal, even opcodes branch on equal.
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 2'b01;
          pc_we      = op_q[0] ? ~zero : zero;
          state_next = FETCH;
        end
        JMP: begin
          pc_we      = 1'b1;
          pc_src     = 2'b10;
          state_next = FETCH;
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Self-checking bench for multicycle_control. Directed steps come first.
//   Randomized instruction streams follow. Expected values come from a
//   reference model: per-instruction state-sequence plans built from the
//   opcode class, plus a per-state output table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, reg_write, mem_to_reg, illegal_op;
  logic [3:0] state_o;
`ifdef MEM_TIMEOUT_EN
  logic       bus_err;
`endif

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
`ifdef MEM_TIMEOUT_EN
    .bus_err(bus_err),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_dst, reg_write, mem_to_reg;
  } ctrl_t;

  ctrl_t obs;
  assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg};

  // One planned cycle: expected state, ack to drive, whether the opcode bus
  // carries the instruction, and the expected sticky flags.
  typedef struct {
    int s;
    bit ack;
    bit pre;
    bit ill;
    bit berr;
  } step_t;

  step_t plan[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Opcode classes: 0=R 1=IMM 2=LOAD 3=STORE 4=BRANCH 5=JUMP 6=ILLEGAL
  function automatic int op_class(input int op);
    if (op == 0) return 0;
    if (op >= 8 && op <= 14) return 1;
    if (op >= 32 && op <= 37) return 2;
    if (op >= 40 && op <= 46) return 3;
    if (op == 1 || (op >= 4 && op <= 7)) return 4;
    if (op == 2) return 5;
    return 6;
  endfunction

  // Control outputs expected in each state.
  function automatic ctrl_t expect_ctrl(input int s, input bit ack,
                                        input bit z, input int op);
    ctrl_t c;
    c = '0;
    case (s)
      0:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_we = ack; c.pc_we = ack; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_req = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      9:  c.reg_write = 1;
      10: begin
            c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01;
            c.pc_we = (op % 2 == 1) ? !z : z;
          end
      11: begin c.pc_we = 1; c.pc_src = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic add(input int s, input bit ack, input bit pre,
                     input bit ill, input bit berr);
    step_t st;
    st.s = s; st.ack = ack; st.pre = pre; st.ill = ill; st.berr = berr;
    plan.push_back(st);
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Builds the cycle plan for one instruction. fd and md are the numbers of
  // wait cycles before the fetch ack and before the data-memory ack.
  task automatic apply_stimulus(input int op, input int fd, input int md);
    repeat (fd) add(0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0);
    add(1, rbit(), 1, 0, 0);
    case (op_class(op))
      0: begin add(6, rbit(), 0, 0, 0); add(7, rbit(), 0, 0, 0); end
      1: begin add(8, rbit(), 0, 0, 0); add(9, rbit(), 0, 0, 0); end
      2: begin
           add(2, rbit(), 0, 0, 0);
           repeat (md) add(3, 0, 0, 0, 0);
           add(3, 1, 0, 0, 0);
           add(4, rbit(), 0, 0, 0);
         end
      3: begin
           add(2, rbit(), 0, 0, 0);
           repeat (md) add(5, 0, 0, 0, 0);
           add(5, 1, 0, 0, 0);
         end
      4: add(10, rbit(), 0, 0, 0);
      5: add(11, rbit(), 0, 0, 0);
      default: begin
           add(12, rbit(), 0, 0, 0);
           repeat (10) add(12, rbit(), 0, 1, 0);
         end
    endcase
  endtask

  // Runs the planned cycles, or only the first 'stop' of them when stop > 0.
  // Inputs are driven 1 time unit after the rising edge. Outputs are checked
  // 1 time unit later. After DECODE the opcode bus carries random values.
  task automatic run_plan(input int op, input bit zbr, input int stop);
    int n;
    n = (stop > 0) ? stop : plan.size();
    for (int i = 0; i < n; i++) begin
      step_t st;
      bit z;
      st = plan[i];
      z = (st.s == 10) ? zbr : rbit();
      @(posedge clk);
      #1;
      mem_ack = st.ack;
      zero    = z;
      opcode  = st.pre ? 6'(op) : 6'($urandom_range(0, 63));
      #1;
      check_output($sformatf("op%0d.step%0d.state", op, i), 32'(state_o), 32'(st.s));
      check_output($sformatf("op%0d.step%0d.ctrl", op, i), 32'(obs),
                   32'(expect_ctrl(st.s, st.ack, z, op)));
      check_output($sformatf("op%0d.step%0d.illegal_op", op, i), 32'(illegal_op), 32'(st.ill));
`ifdef MEM_TIMEOUT_EN
      check_output($sformatf("op%0d.step%0d.bus_err", op, i), 32'(bus_err), 32'(st.berr));
`endif
    end
    plan.delete();
  endtask

  // Asserts reset in the middle of a cycle. Outputs are checked while reset
  // is active and again just after release. The first request should start
  // only on the following clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("reset.ctrl", 32'(obs), 32'd0);
    check_output("reset.state", 32'(state_o), 32'd0);
    check_output("reset.illegal_op", 32'(illegal_op), 32'd0);
`ifdef MEM_TIMEOUT_EN
    check_output("reset.bus_err", 32'(bus_err), 32'd0);
`endif
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_output("release.ctrl_before_clk", 32'(obs), 32'd0);
  endtask

  function automatic int rand_op();
    int v;
    int br[5] = '{1, 4, 5, 6, 7};
    case ($urandom_range(0, 6))
      0: v = 0;
      1: v = $urandom_range(8, 14);
      2: v = $urandom_range(32, 37);
      3: v = $urandom_range(40, 46);
      4: v = br[$urandom_range(0, 4)];
      5: v = 2;
      default: begin
        v = $urandom_range(0, 63);
        while (op_class(v) != 6) v = $urandom_range(0, 63);
      end
    endcase
    return v;
  endfunction

  initial begin
    int op;
    do_reset();

    // lw with its data access interrupted by reset while still in MRD
    apply_stimulus(35, 0, 3);
    run_plan(35, 0, 5);
    do_reset();

    // R-type with an immediate fetch ack
    apply_stimulus(0, 0, 0);
    run_plan(0, 0, 0);
    // lw with data ack delayed by 3 cycles
    apply_stimulus(35, 0, 3);
    run_plan(35, 0, 0);
    // sw with a slow fetch
    apply_stimulus(43, 2, 1);
    run_plan(43, 0, 0);
    // branch taken on equal and not taken on not-equal, both with zero=1
    apply_stimulus(4, 0, 0);
    run_plan(4, 1, 0);
    apply_stimulus(5, 0, 0);
    run_plan(5, 1, 0);
    // immediate class and jump
    apply_stimulus(9, 1, 0);
    run_plan(9, 0, 0);
    apply_stimulus(2, 0, 0);
    run_plan(2, 0, 0);
    // illegal opcode locks up until reset
    apply_stimulus(63, 0, 0);
    run_plan(63, 0, 0);
    do_reset();

`ifdef MEM_TIMEOUT_EN
    // no fetch ack for 16 cycles leads to FAULT and bus_err
    repeat (16) add(0, 0, 1, 0, 0);
    add(13, rbit(), 0, 0, 0);
    repeat (3) add(13, rbit(), 0, 0, 1);
    run_plan(0, 0, 0);
    do_reset();
    // an ack on the 16th cycle still completes normally
    apply_stimulus(0, 15, 0);
    run_plan(0, 0, 0);
`endif

    // random instruction stream
    for (int k = 0; k < 150; k++) begin
      op = rand_op();
      apply_stimulus(op, $urandom_range(0, 3), $urandom_range(0, 3));
      run_plan(op, rbit(), 0);
      if (op_class(op) == 6) do_reset();
    end

    $display("[TB] random stream done");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
